// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request front-end.
// Optional input synchronizer enabled by defining IRQ_SYNC_EN.
package irq_pkg;

  localparam int NSRC = 8;
  localparam int IDW  = 3;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_OFFER
  } irq_state_e;

  // Returns {found, id} with the highest set index winning.
  function automatic logic [IDW:0] irq_pick(
    input logic [NSRC-1:0] cand
  );
    logic [IDW:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (cand[i]) r = {1'b1, IDW'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_line_capture.sv
// Per-line request capture: optional sync, sample, pending and overflow.
// IRQ_SYNC_EN adds a 2-flop synchronizer ahead of sampling.
module irq_line_capture
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack_clr,
  input  logic ovf_clr,
  output logic pending,
  output logic overflow
);

  logic src;

`ifdef IRQ_SYNC_EN
  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= req;
      s2 <= s1;
    end
  end

  assign src = s2;
`else
  assign src = req;
`endif

  if (EDGE) begin : g_edge
    logic smp;
    logic rise;
    logic ovf_set;

    assign rise    = src & ~smp;
    // A set coinciding with the ack-clear keeps the line pending silently.
    assign ovf_set = rise & pending & ~ack_clr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        smp      <= 1'b0;
        pending  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        smp      <= src;
        pending  <= rise | (pending & ~ack_clr);
        overflow <= ovf_set | (overflow & ~ovf_clr);
      end
    end
  end else begin : g_level
    logic unused_in;

    assign unused_in = ack_clr ^ ovf_clr;
    assign overflow  = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= 1'b0;
      else        pending <= src;
    end
  end

endmodule

// File: rtl/irq_request_latch.sv
// Interrupt request latch: enable mask, winner select, valid/ack offer FSM.
// Define IRQ_SYNC_EN to synchronize req_in inside each line capture.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter logic [NSRC-1:0] EDGE_MODE = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] req_in,
  input  logic            en_wr,
  input  logic [NSRC-1:0] en_data,
  output logic [NSRC-1:0] en_q,
  output logic [NSRC-1:0] pending,
  output logic            irq_valid,
  output logic [IDW-1:0]  irq_id,
  input  logic            irq_ack,
  output logic [NSRC-1:0] overflow,
  input  logic            ovf_clr
);

  irq_state_e     state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW:0]   pick;
  logic [NSRC-1:0] ack_clr;

  for (genvar i = 0; i < NSRC; i++) begin : g_line
    assign ack_clr[i] = irq_valid & irq_ack
                      & (id_q == IDW'(i));

    irq_line_capture #(
      .EDGE (EDGE_MODE[i])
    ) u_cap (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req_in[i]),
      .ack_clr  (ack_clr[i]),
      .ovf_clr  (ovf_clr),
      .pending  (pending[i]),
      .overflow (overflow[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     en_q <= '0;
    else if (en_wr) en_q <= en_data;
  end

  assign pick = irq_pick(pending & en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // The offered id is frozen until the consumer acks it.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (pick[IDW]) begin
          id_d    = pick[IDW-1:0];
          state_d = IRQ_OFFER;
        end
      end
      IRQ_OFFER: begin
        if (irq_ack) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  assign irq_valid = (state_q == IRQ_OFFER);
  assign irq_id    = id_q;

endmodule
